mem_access_seq: RTL and testbench

- Memory-stage controller that sequences one data-memory access per request through the pointer address mux.
- Drives the mux select (00 SP, 01 X, 10 Y, 11 Z), issues the memory enable/write, and waits on the memory ready handshake.
- Performs pointer pre-decrement / post-increment through the pointer-register write port, and returns read data with a one-cycle done pulse.

---
 rtl/mem_access_seq_if.sv | 43 ++++
 rtl/mem_access_seq.sv | 167 ++++++++++++++++
 tb/tb_mem_access_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: request, data-memory and pointer-port signals of the
// memory-stage access sequencer.
//   slave  : sequencer view (receives requests, drives memory and pointer port)
//   master : environment view (issues requests, models memory and pointer file)
interface mem_access_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_ptr_sel;
  logic [1:0]        req_mode;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] ptr_addr;
  logic [1:0]        addr_sel;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              ptr_wr_en;
  logic [1:0]        ptr_wr_sel;
  logic [ADDR_W-1:0] ptr_wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_write, req_ptr_sel, req_mode, req_wdata,
    input  ptr_addr, mem_ready, mem_rdata,
    output addr_sel, mem_en, mem_we, mem_wdata,
    output ptr_wr_en, ptr_wr_sel, ptr_wr_data,
    output rd_data, done, err
  );

  modport master (
    output req_valid, req_write, req_ptr_sel, req_mode, req_wdata,
    output ptr_addr, mem_ready, mem_rdata,
    input  addr_sel, mem_en, mem_we, mem_wdata,
    input  ptr_wr_en, ptr_wr_sel, ptr_wr_data,
    input  rd_data, done, err
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences one data-memory access per request through the
// pointer address mux, with optional pointer pre-decrement / post-increment
// and a one-cycle done pulse.
//
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN
//   defined   : ACCESS wait is bounded by TIMEOUT_CYCLES; expiry ends the
//               access with err=1, rd_data=0 and no post-increment.
//   undefined : ACCESS waits for mem_ready indefinitely; err is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req_valid; request fields latched on acceptance
// PREDEC  | writes ptr_addr-1 back to the selected pointer register
// ACCESS  | mem_en high until mem_ready (or timeout, when enabled)
// POSTINC | writes ptr_addr+1 back to the selected pointer register
// DONE    | one-cycle done pulse, req_valid ignored
module mem_access_seq #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  mem_access_seq_if.slave   io_bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("mem_access_seq: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREDEC  = 3'd1,
    S_ACCESS  = 3'd2,
    S_POSTINC = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_POSTINC = 2'b01;
  localparam logic [1:0] MODE_PREDEC  = 2'b10;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_write;
  logic [1:0]        r_sel;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_accept;
  logic              w_tmo;

  assign w_accept = (r_state == S_IDLE) && io_bus.req_valid;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Wait timer: reloaded outside ACCESS, counts down once per waiting cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state != S_ACCESS) begin
      r_cnt <= CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Terminal count reached on the last allowed ACCESS cycle without ready.
  assign w_tmo = (r_state == S_ACCESS) && !io_bus.mem_ready && (r_cnt == '0);

  // Error flag lives from the timeout edge until the DONE cycle ends.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_err <= 1'b0;
    end else if (w_tmo) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; mode 11 falls through to the plain path.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid) begin
          w_state_nxt = (io_bus.req_mode == MODE_PREDEC) ? S_PREDEC : S_ACCESS;
        end
      end
      S_PREDEC:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (io_bus.mem_ready) begin
          w_state_nxt = (r_mode == MODE_POSTINC) ? S_POSTINC : S_DONE;
        end else if (w_tmo) begin
          w_state_nxt = S_DONE;
        end
      end
      S_POSTINC: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields latched on acceptance; load data captured on the ready edge.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_write   <= 1'b0;
      r_sel     <= 2'b00;
      r_mode    <= 2'b00;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_write <= io_bus.req_write;
        r_sel   <= io_bus.req_ptr_sel;
        r_mode  <= io_bus.req_mode;
        r_wdata <= io_bus.req_wdata;
      end
      if ((r_state == S_ACCESS) && io_bus.mem_ready && !r_write) begin
        r_rd_data <= io_bus.mem_rdata;
      end else if (w_tmo) begin
        r_rd_data <= '0;
      end
    end
  end

  // Outputs decoded from state and latched fields only.
  always_comb begin
    io_bus.addr_sel    = r_sel;
    io_bus.mem_en      = (r_state == S_ACCESS);
    io_bus.mem_we      = (r_state == S_ACCESS) && r_write;
    io_bus.mem_wdata   = r_wdata;
    io_bus.ptr_wr_en   = (r_state == S_PREDEC) || (r_state == S_POSTINC);
    io_bus.ptr_wr_sel  = r_sel;
    io_bus.ptr_wr_data = '0;
    if (r_state == S_PREDEC) begin
      io_bus.ptr_wr_data = io_bus.ptr_addr - ADDR_W'(1);
    end else if (r_state == S_POSTINC) begin
      io_bus.ptr_wr_data = io_bus.ptr_addr + ADDR_W'(1);
    end
    io_bus.rd_data     = r_rd_data;
    io_bus.done        = (r_state == S_DONE);
`ifdef MEM_ACCESS_TIMEOUT_EN
    io_bus.err         = (r_state == S_DONE) && r_err;
`else
    io_bus.err         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table-driven request vectors with a scoreboard queue,
// plus hand-written sequences for back-to-back requests and mid-access reset.
// Models the pointer register file and data memory around the sequencer.
`timescale 1ns/1ps
module tb_mem_access_seq;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .io_bus   (bus.slave)
  );

  // Pointer register file: preset port for the bench, write port for the DUT.
  logic [ADDR_W-1:0] ptr_regs [4];
  logic              pre_en = 1'b0;
  logic [1:0]        pre_sel = 2'b00;
  logic [ADDR_W-1:0] pre_val = '0;

  always @(posedge clk) begin
    if (pre_en) ptr_regs[pre_sel] <= pre_val;
    else if (bus.ptr_wr_en) ptr_regs[bus.ptr_wr_sel] <= bus.ptr_wr_data;
  end
  assign bus.ptr_addr = ptr_regs[bus.addr_sel];

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic [7:0]  wdata;
    logic [15:0] ptr0;
    logic [7:0]  rdata;
    int          ready_lo;
    int          exp_lat;
    int          exp_en;
    int          exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_ptr;
    logic [15:0] exp_wrdata;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preset_ptr(input logic [1:0] sel, input logic [15:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_sel = sel; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issues one request, plays memory, then checks against the scoreboard entry.
  task automatic do_req(input vec_t v, input bit hold, input string tag);
    vec_t        e;
    int          cyc, en_cnt, wr_cnt;
    bit          got_done, overlap;
    logic        err_seen, we_seen;
    logic [15:0] addr_seen, wr_data_seen;
    logic [1:0]  wr_sel_seen;
    logic [7:0]  wd_seen;
    preset_ptr(v.sel, v.ptr0);
    sb.push_back(v);
    bus.req_valid = 1'b1; bus.req_write = v.wr; bus.req_ptr_sel = v.sel;
    bus.req_mode = v.mode; bus.req_wdata = v.wdata;
    bus.mem_rdata = v.rdata; bus.mem_ready = 1'b0;
    cyc = 0; en_cnt = 0; wr_cnt = 0; got_done = 0; overlap = 0;
    err_seen = 0; we_seen = 0; addr_seen = '0; wr_data_seen = '0; wr_sel_seen = '0; wd_seen = '0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_en) begin
        en_cnt++; addr_seen = bus.ptr_addr; we_seen = bus.mem_we; wd_seen = bus.mem_wdata;
      end
      if (bus.ptr_wr_en) begin
        wr_cnt++; wr_data_seen = bus.ptr_wr_data; wr_sel_seen = bus.ptr_wr_sel;
      end
      if (bus.mem_en && bus.ptr_wr_en) overlap = 1;
      bus.mem_ready = bus.mem_en && (en_cnt > v.ready_lo);
      if (bus.done) begin
        got_done = 1; err_seen = bus.err;
        if (!hold) bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
      end
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_latency"}, cyc, e.exp_lat);
    check({tag, "_mem_en_cycles"}, en_cnt, e.exp_en);
    check({tag, "_ptr_wr_count"}, wr_cnt, e.exp_wr);
    check({tag, "_access_addr"}, 32'(addr_seen), 32'(e.exp_addr));
    check({tag, "_mem_we"}, 32'(we_seen), 32'(e.wr));
    if (e.wr) check({tag, "_mem_wdata"}, 32'(wd_seen), 32'(e.wdata));
    if (e.exp_wr > 0) begin
      check({tag, "_ptr_wr_data"}, 32'(wr_data_seen), 32'(e.exp_wrdata));
      check({tag, "_ptr_wr_sel"}, 32'(wr_sel_seen), 32'(e.sel));
    end
    check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(e.exp_rd));
    check({tag, "_ptr_final"}, 32'(ptr_regs[e.sel]), 32'(e.exp_ptr));
    check({tag, "_err"}, 32'(err_seen), 32'(e.exp_err));
    check({tag, "_en_wr_overlap"}, 32'(overlap), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_gap_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_err_after_done"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    //            wr  sel    mode   wdata  ptr0      rdata  rlo  lat en wr addr      ptr       wrdata    rd     err
    vecs.push_back('{1'b0, 2'b00, 2'b00, 8'h00, 16'h1234, 8'hA5, 0,   2, 1, 0, 16'h1234, 16'h1234, 16'h0000, 8'hA5, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 2'b10, 8'h3C, 16'h0000, 8'hFF, 0,   3, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hA5, 1'b0});
    vecs.push_back('{1'b0, 2'b11, 2'b01, 8'h00, 16'hFFFF, 8'h5A, 3,   6, 4, 1, 16'hFFFF, 16'h0000, 16'h0000, 8'h5A, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 2'b11, 8'h00, 16'h8000, 8'h77, 0,   2, 1, 0, 16'h8000, 16'h8000, 16'h0000, 8'h77, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 2'b00, 8'hC3, 16'h0100, 8'h99, 1,   3, 2, 0, 16'h0100, 16'h0100, 16'h0000, 8'h77, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 2'b10, 8'h00, 16'h0001, 8'h11, 2,   5, 3, 1, 16'h0000, 16'h0000, 16'h0000, 8'h11, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 2'b01, 8'hEE, 16'h7FFF, 8'h00, 0,   3, 1, 1, 16'h7FFF, 16'h8000, 16'h8000, 8'h11, 1'b0});
`ifdef MEM_ACCESS_TIMEOUT_EN
    vecs.push_back('{1'b0, 2'b11, 2'b01, 8'h00, 16'h0020, 8'hAB, 1000, 5, 4, 0, 16'h0020, 16'h0020, 16'h0000, 8'h00, 1'b1});
`endif

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_ptr_sel = 2'b00;
    bus.req_mode = 2'b00; bus.req_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr_sel", 32'(bus.addr_sel), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_ptr_wr_en", 32'(bus.ptr_wr_en), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_ptr_wr_data", 32'(bus.ptr_wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_req(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Mode 11 on Y with req_valid still high after done: one IDLE cycle, then re-accept.
    hv = '{1'b0, 2'b10, 2'b11, 8'h00, 16'h4000, 8'h66, 0, 2, 1, 0, 16'h4000, 16'h4000, 16'h0000, 8'h66, 1'b0};
    do_req(hv, 1'b1, "hold");
    bus.mem_rdata = 8'h67;
    @(negedge clk);
    check("hold_reaccept_mem_en", 32'(bus.mem_en), 32'd1);
    check("hold_reaccept_addr", 32'(bus.ptr_addr), 32'h4000);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("hold_second_done", 32'(bus.done), 32'd1);
    check("hold_second_rd_data", 32'(bus.rd_data), 32'h67);
    bus.req_valid = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);

    // Reset during the ACCESS phase of a pre-decrement load on X.
    preset_ptr(2'b01, 16'h0050);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_ptr_sel = 2'b01;
    bus.req_mode = 2'b10; bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rstmid_predec_wr_en", 32'(bus.ptr_wr_en), 32'd1);
    check("rstmid_predec_data", 32'(bus.ptr_wr_data), 32'h004F);
    @(negedge clk);
    check("rstmid_access_mem_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_en", 32'(bus.mem_en), 32'd0);
    check("rstmid_addr_sel", 32'(bus.addr_sel), 32'd0);
    check("rstmid_rd_data", 32'(bus.rd_data), 32'd0);
    check("rstmid_ptr_wr_en", 32'(bus.ptr_wr_en), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_ptr_kept", 32'(ptr_regs[1]), 32'h004F);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_after_done", 32'(bus.done), 32'd0);
    check("rstmid_after_mem_en", 32'(bus.mem_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
